// File: rtl/blocks_to_hdmi.sv
// blocks_to_hdmi: re-rasterises an 8x8 YCbCr block stream onto free-running HDMI-style timing via ping-pong 8-line strip banks
module blocks_to_hdmi #(
  parameter int N = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200,
  parameter int H_SYNC_CYC = 20,
  parameter int H_BACK_PORCH_CYC = 46,
  parameter int H_FRONT_PORCH_CYC = 40,
  parameter int V_SYNC_CYC = 2,
  parameter int V_BACK_PORCH_CYC = 24,
  parameter int V_FRONT_PORCH_CYC = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic signed [N-1:0][7:0] blk_data_y,
  input  logic signed [N-1:0][7:0] blk_data_cr,
  input  logic signed [N-1:0][7:0] blk_data_cb,
  input  logic                    blk_sob,
  input  logic                    blk_eob,
  input  logic                    blk_sof,
  output logic                    hdmi_v_sync,
  output logic                    hdmi_h_sync,
  output logic                    hdmi_data_valid,
  output logic signed [N-1:0][7:0] hdmi_data_y,
  output logic signed [N-1:0][7:0] hdmi_data_cr,
  output logic signed [N-1:0][7:0] hdmi_data_cb,
  output logic                    underflow,
  output logic                    sync_err
);
  localparam int XW = X_RES / N;
  localparam int NB = X_RES / 8;
  localparam int BPR = 8 / N;
  localparam int KB = 64 / N;
  localparam int HT = H_SYNC_CYC + H_BACK_PORCH_CYC + XW + H_FRONT_PORCH_CYC;
  localparam int VT = V_SYNC_CYC + V_BACK_PORCH_CYC + Y_RES + V_FRONT_PORCH_CYC;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int XAW = XW > 1 ? $clog2(XW) : 1;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int KW = $clog2(KB);
  localparam logic [HW-1:0] H_S = HW'(H_SYNC_CYC);
  localparam logic [HW-1:0] H_A0 = HW'(H_SYNC_CYC + H_BACK_PORCH_CYC);
  localparam logic [HW-1:0] H_AE = HW'(H_SYNC_CYC + H_BACK_PORCH_CYC + XW - 1);
  localparam logic [HW-1:0] H_L = HW'(HT - 1);
  localparam logic [VW-1:0] V_S = VW'(V_SYNC_CYC);
  localparam logic [VW-1:0] V_A0 = VW'(V_SYNC_CYC + V_BACK_PORCH_CYC);
  localparam logic [VW-1:0] V_A1 = VW'(V_SYNC_CYC + V_BACK_PORCH_CYC + Y_RES);
  localparam logic [VW-1:0] V_L = VW'(VT - 1);
  localparam logic [KW-1:0] K_L = KW'(KB - 1);
  localparam logic [BW-1:0] B_L = BW'(NB - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0] full;
  logic wr_bank, rd_bank, show, vis;
  logic [BW-1:0] blk_idx, eb;
  logic [KW-1:0] k, ek;
  logic [24*N-1:0] mem [2][8][XW];
  logic [24*N-1:0] rd_q;
  logic h_last, v_act, act, strip_start, strip_end, show_now;
  logic [2:0] row_rd, wr_row;
  logic [XAW-1:0] x, wr_word;
  logic acc, resync, err, last_k, done;

  always_comb begin
    h_last = h_cnt == H_L;
    v_act = v_cnt >= V_A0 && v_cnt < V_A1;
    act = v_act && h_cnt >= H_A0 && h_cnt <= H_AE;
    row_rd = 3'(v_cnt - V_A0);
    x = XAW'(h_cnt - H_A0);
    strip_start = v_act && h_cnt == H_A0 && row_rd == 3'd0;
    strip_end = v_act && h_cnt == H_AE && row_rd == 3'd7 && show;
    show_now = strip_start ? full[rd_bank] : show;
    blk_ready = rst_n & en & ~full[wr_bank];
    acc = blk_valid & blk_ready;
    // a stray sof restarts the current bank at block 0, beat 0
    resync = blk_sof && (blk_idx != '0 || k != '0);
    ek = resync ? '0 : k;
    eb = resync ? '0 : blk_idx;
    err = resync || (blk_sob != (ek == '0)) || (blk_eob != (ek == K_L));
    last_k = ek == K_L;
    done = acc && last_k && eb == B_L;
    wr_row = 3'(int'(ek) / BPR);
    wr_word = XAW'(int'(eb) * BPR + int'(ek) % BPR);
    {hdmi_data_cb, hdmi_data_cr, hdmi_data_y} = vis ? rd_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      show <= 1'b0;
      blk_idx <= '0;
      k <= '0;
      hdmi_h_sync <= 1'b0;
      hdmi_v_sync <= 1'b0;
      hdmi_data_valid <= 1'b0;
      vis <= 1'b0;
      underflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) v_cnt <= (v_cnt == V_L) ? '0 : v_cnt + VW'(1);
      // set on the write bank and clear on the read bank may coincide
      full <= (full | (done ? 2'b01 << wr_bank : 2'b00)) & ~(strip_end ? 2'b01 << rd_bank : 2'b00);
      if (done) wr_bank <= ~wr_bank;
      if (strip_end) rd_bank <= ~rd_bank;
      show <= strip_end ? 1'b0 : show_now;
      if (acc) begin
        k <= last_k ? '0 : ek + KW'(1);
        blk_idx <= last_k ? (eb == B_L ? '0 : eb + BW'(1)) : eb;
      end
      hdmi_h_sync <= h_cnt < H_S;
      hdmi_v_sync <= v_cnt < V_S;
      hdmi_data_valid <= act;
      vis <= act && show_now && en;
      underflow <= strip_start && !full[rd_bank];
      sync_err <= acc && err;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_bank][wr_row][wr_word] <= {blk_data_cb, blk_data_cr, blk_data_y};
    rd_q <= mem[rd_bank][row_rd][x];
  end
endmodule
